// File: rtl/seq_detect_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_ctrl_if
//  Description : Host/stream bundle for the sequence-detector run controller.
//                Carries the run controls, the pattern configuration, the
//                serial input stream and the run status outputs.
//                master : host/config side (drives controls, config and stream)
//                slave  : seq_detect_ctrl (drives the status outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_detect_ctrl_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] cfg_pattern;
    logic [3:0]       cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic [TMO_W-1:0] cfg_timeout;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             done;
    logic             timed_out;

    modport master (
        output start, abort, cfg_pattern, cfg_len, cfg_overlap,
               cfg_target, cfg_timeout, x, x_valid,
        input  busy, match, match_count, done, timed_out
    );

    modport slave (
        input  start, abort, cfg_pattern, cfg_len, cfg_overlap,
               cfg_target, cfg_timeout, x, x_valid,
        output busy, match, match_count, done, timed_out
    );
endinterface
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_ctrl
//  Description : Run controller for a serial bit-pattern detector. Starts and
//                stops a detection run, matches a programmable pattern of
//                1..PAT_W bits (overlapping or not), counts matches up to a
//                target and ends the run on target, timeout or abort.
//                The default configuration (pattern 1011, len 4) reproduces
//                the classic 1011 Mealy detector.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous active-high reset
//                bus   - seq_detect_ctrl_if.slave: start/abort, cfg_*,
//                        x/x_valid in; busy, match, match_count, done,
//                        timed_out out
//  Notes       : PAT_W must be at least 2 (history is PAT_W-1 bits).
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    seq_detect_ctrl_if.slave  bus
);

    localparam int c_FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Configuration frozen at run start
    logic [PAT_W-1:0]    r_pattern;
    logic [3:0]          r_len;
    logic                r_overlap;
    logic [CNT_W-1:0]    r_target;
    logic [TMO_W-1:0]    r_timeout;

    // Run datapath
    logic [PAT_W-2:0]    r_history;
    logic [c_FILL_W-1:0] r_fill;
    logic [TMO_W-1:0]    r_timer;
    logic [CNT_W-1:0]    r_count;
    logic                r_timed_out;

    logic [3:0]          w_len_eff;
    logic [PAT_W-1:0]    w_window;
    logic [PAT_W-1:0]    w_mask;
    logic                w_in_run;
    logic                w_pat_eq;
    logic                w_fill_ok;
    logic                w_match;
    logic [CNT_W-1:0]    w_count_inc;
    logic                w_hit_target;
    logic                w_hit_timeout;
    logic                w_accept;

    // Effective length: 0 behaves as 1, anything beyond PAT_W is clamped.
    always_comb begin
        w_len_eff = bus.cfg_len;
        if (bus.cfg_len == 4'd0) begin
            w_len_eff = 4'd1;
        end else if (int'(bus.cfg_len) > PAT_W) begin
            w_len_eff = 4'(PAT_W);
        end
    end

    // Only the low r_len bits of the window take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    // The newest bit sits at window bit 0, matching cfg_pattern bit 0.
    assign w_window  = {r_history, bus.x};
    assign w_in_run  = (r_state == ST_RUN);
    assign w_pat_eq  = (((w_window ^ r_pattern) & w_mask) == '0);
    // Enough bits must have arrived since the run start (or last
    // non-overlap match) so stale/cleared history never forms a match.
    assign w_fill_ok = ((int'(r_fill) + 1) >= int'(r_len));
    assign w_match   = w_in_run & bus.x_valid & ~bus.abort & w_fill_ok & w_pat_eq;

    assign w_count_inc   = (r_count == '1) ? r_count : r_count + CNT_W'(1);
    assign w_hit_target  = w_match && (r_target != '0) && (w_count_inc == r_target);
    assign w_hit_timeout = (r_timeout != '0) && (r_timer == r_timeout - TMO_W'(1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // start wins over a simultaneous abort; abort alone is a no-op
                if (bus.start) begin
                    w_state_next = ST_RUN;
                    w_accept     = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_hit_target || w_hit_timeout) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Config capture and run datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern   <= '0;
            r_len       <= 4'd1;
            r_overlap   <= 1'b0;
            r_target    <= '0;
            r_timeout   <= '0;
            r_history   <= '0;
            r_fill      <= '0;
            r_timer     <= '0;
            r_count     <= '0;
            r_timed_out <= 1'b0;
        end else if (w_accept) begin
            r_pattern   <= bus.cfg_pattern;
            r_len       <= w_len_eff;
            r_overlap   <= bus.cfg_overlap;
            r_target    <= bus.cfg_target;
            r_timeout   <= bus.cfg_timeout;
            r_history   <= '0;
            r_fill      <= '0;
            r_timer     <= '0;
            r_count     <= '0;
            r_timed_out <= 1'b0;
        end else if (w_in_run && !bus.abort) begin
            r_timer <= r_timer + TMO_W'(1);
            if (bus.x_valid) begin
                if (w_match && !r_overlap) begin
                    r_history <= '0;
                    r_fill    <= '0;
                end else begin
                    r_history <= w_window[PAT_W-2:0];
                    if (r_fill != c_FILL_W'(PAT_W)) begin
                        r_fill <= r_fill + c_FILL_W'(1);
                    end
                end
            end
            if (w_match) begin
                r_count <= w_count_inc;
            end
            // Target completion takes precedence over a coincident timeout.
            if (w_hit_timeout && !w_hit_target) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    assign bus.busy        = (r_state == ST_RUN);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.match       = w_match;
    assign bus.match_count = r_count;
    assign bus.timed_out   = r_timed_out;

endmodule
`default_nettype wire

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Run controller for the serial bit-pattern detector datapath.
- Starts and stops a detection run and applies a programmable pattern (length 1..PAT_W, overlap or non-overlap).
- Counts matches up to a target and ends the run on target, timeout or abort.
- Sits between the host/config logic and the serial input stream; the default configuration reproduces the 1011 Mealy detector.

Parameters:
PAT_W, 8, maximum pattern length in bits
CNT_W, 8, match counter width
TMO_W, 16, run timeout counter width (clock cycles)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-high reset
start  input  1  begin run; sampled only in IDLE
abort  input  1  terminate run immediately
cfg_pattern  input  PAT_W  pattern; bit 0 = last-received bit
cfg_len  input  4  pattern length; 0 treated as 1, >PAT_W clamped to PAT_W
cfg_overlap  input  1  1 = overlapping matches allowed
cfg_target  input  CNT_W  matches to end run; 0 = unlimited
cfg_timeout  input  TMO_W  run cycle limit; 0 = disabled
x  input  1  serial data bit
x_valid  input  1  x is valid this cycle
busy  output  1  high in RUN
match  output  1  Mealy match pulse
match_count  output  CNT_W  matches in current or last run
done  output  1  one-cycle pulse on normal or timeout completion
timed_out  output  1  last run ended by timeout

Behaviour:
- Reset (async, reset=1):
  - state=IDLE.
  - busy, match, done, timed_out, match_count, history, fill, timer all 0.
- Config capture: cfg_* are registered on the accepted start edge. Changes to cfg_* during RUN have no effect.
- States IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN next cycle.
  - On that transition: clear match_count, timed_out, history, fill and timer.
  - abort in IDLE is ignored. start has priority if start and abort are both asserted.
- RUN, bit handling (on x_valid=1 only):
  - window = {history, x}. history is a (PAT_W-1)-bit shift register.
  - fill = number of valid bits since run start or last non-overlap match; saturates at PAT_W.
  - match = RUN & x_valid & ~abort & (fill+1 >= len) & (low len bits of window == low len bits of cfg_pattern).
  - match is combinational from x in the same cycle as the final pattern bit (zero latency).
  - On the clock edge: history shifts in x and fill increments.
  - On a match with cfg_overlap=0: history and fill clear instead of shifting.
  - On a match: match_count increments, saturating at all-ones.
- RUN, timer: increments every RUN cycle, with or without x_valid.
- RUN, exits (priority order):
  1. abort=1 -> IDLE next cycle. No done; this cycle's bit is not counted; match_count held.
  2. Target reached: cfg_target != 0 and this cycle's match makes match_count equal cfg_target -> DONE, timed_out=0.
  3. Timeout: cfg_timeout != 0 and timer == cfg_timeout-1 -> DONE, timed_out=1.
  - If target and timeout occur in the same cycle, the target wins.
- DONE:
  - Lasts exactly one cycle with done=1, busy=0, then -> IDLE.
  - start during DONE is ignored.
- busy = (state==RUN), registered.
- match_count and timed_out hold after the run until the next accepted start.
- start during RUN is ignored; it does not restart the run.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0; no done pulse.

Test Plan:
- Overlap counting:
  - Config: pattern=8'b00001011, len=4, overlap=1, target=2, timeout=0; start.
  - Stream 1,0,1,1,0,1,1 with x_valid=1.
  - Expect: match on bits 4 and 7; match_count=2; done pulse the cycle after bit 7; busy low in that same cycle.
- Non-overlap:
  - Same config with overlap=0, target=0.
  - Stream 1,0,1,1,0,1,1,0,1,1.
  - Expect: match on bits 4 and 10 only; match_count=2; run continues (busy=1).
- Timeout:
  - Config: target=3, timeout=10; stream all 0.
  - Expect: done pulse in cycle 11 after start acceptance; timed_out=1; match_count=0.
  - Variant: target reached on the timeout cycle -> timed_out=0.
- Abort and gaps:
  - Stream 1,0,1 with x_valid low between bits; assert abort with the 4th bit (1).
  - Expect: no match, match_count=0, no done, IDLE next cycle.
- Ignored start / config freeze:
  - Pulse start and change cfg_pattern during RUN.
  - Expect: no restart; the original pattern is still detected.
- Async reset mid-run:
  - Assert reset between clock edges after 1 match.
  - Expect: busy, match_count and timed_out go to 0 immediately; IDLE after release.
